// File: rtl/apb_completer_regs.sv
// apb_completer_regs
//   APB completer that holds the configuration register bank of the DFE
//   filter array. It decodes the setup and access phases of one PSEL line and
//   inserts WAIT_STATES wait cycles before it completes each transfer. Writes
//   are committed to a word-addressed register file. The top index is a
//   read-only STATUS word taken from the datapath.
//
// Ports
//   PCLK, PRESETn   APB clock; asynchronous active-low reset
//   PSEL, PENABLE   select and access-phase indicator from the bridge
//   PWRITE          1 = write, 0 = read
//   PADDR, PWDATA   byte address and write data, latched in the setup phase
//   PRDATA          read data; 0 unless a read is completing without error
//   PREADY          transfer completion
//   PSLVERR         error response; only ever 1 together with PREADY
//   cfg_regs        flat config vector, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse        one-cycle strobe per reg, raised the cycle after its write
//   status_in       datapath status, returned on reads of the STATUS index
module apb_completer_regs #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [DATA_WIDTH-1:0]          status_in
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  wr_p0, err_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]      idx;
  logic                  addr_bad, setup, complete, commit_wr;

  // Address bits above the index field must all be zero.
  assign idx       = PADDR[IDX_W+1:2];
  assign addr_bad  = (PADDR[1:0] != 2'b00) || ((PADDR >> (IDX_W + 2)) != '0);
  assign setup     = (state == IDLE) && PSEL && !PENABLE;
  assign complete  = (state == ACCESS) && PSEL && PENABLE && (cnt == 4'd0);
  assign commit_wr = complete && wr_p0 && !err_p0;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        // PSEL with PENABLE already high means no setup phase was seen, so it is ignored.
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;  // abort: drop the transfer without a response
        end else if (PENABLE) begin
          if (cnt != 4'd0) cnt_d = cnt - 4'd1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Setup stage: capture control fields of the transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wr_p0  <= 1'b0;
      err_p0 <= 1'b0;
      idx_p0 <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (setup) begin
        wr_p0  <= PWRITE;
        idx_p0 <= idx;
        err_p0 <= addr_bad || (PWRITE && (idx == STATUS_IDX));
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (setup) wdata_p0 <= PWDATA;
  end

  // Commit stage: register file update and write strobe
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit_wr) begin
        regs[idx_p0]     <= wdata_p0;
        wr_pulse[idx_p0] <= 1'b1;
      end
    end
  end

  assign PREADY  = complete;
  assign PSLVERR = complete && err_p0;

  always_comb begin
    PRDATA = '0;
    if (complete && !wr_p0 && !err_p0) begin
      PRDATA = (idx_p0 == STATUS_IDX) ? status_in : regs[idx_p0];
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
    if (i == NUM_REGS - 1) begin : g_status
      assign cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      assign cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

endmodule

// File: doc/apb_completer_regs.md
# apb_completer_regs

APB completer (peripheral side) holding the DFE filter array's configuration register bank. It answers one `PSELx` line of the APB bridge and decodes setup/access phases. It inserts a programmable number of wait states, commits writes to a word-addressed register file, and returns read data and error responses. Register contents feed the filter datapath as a flat vector; a status word from the datapath is exposed read-only.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `PADDR`.
- `DATA_WIDTH`, 32: register and bus data width.
- `NUM_REGS`, 16: register count, a power of 2 and at least 2. Indices 0..NUM_REGS-2 are RW config; index NUM_REGS-1 is RO STATUS.
- `WAIT_STATES`, 1: access-phase cycles with `PREADY`=0 before completion, range 0..15.

Ports. One clock (`PCLK`); reset `PRESETn` is asynchronous and active-low.
- `PCLK`  in  1  APB clock.
- `PRESETn`  in  1  asynchronous active-low reset.
- `PSEL`  in  1  this completer's select bit (one bit of the bridge's `PSELx`).
- `PENABLE`  in  1  access-phase indicator.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDR`  in  ADDR_WIDTH  byte address.
- `PWDATA`  in  DATA_WIDTH  write data.
- `PRDATA`  out  DATA_WIDTH  read data; valid only while `PREADY`=1 on a read, 0 otherwise.
- `PREADY`  out  1  transfer completion.
- `PSLVERR`  out  1  error response; meaningful only while `PREADY`=1.
- `cfg_regs`  out  NUM_REGS*DATA_WIDTH  flat config vector. Reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. The STATUS slot is driven 0.
- `wr_pulse`  out  NUM_REGS  one-cycle strobe for reg i, asserted the cycle after reg i is written.
- `status_in`  in  DATA_WIDTH  datapath status, sampled at read completion.

## Operation
- Address decode:
  - `idx` = `PADDR[$clog2(NUM_REGS)+1:2]`.
  - The address is invalid if `PADDR[1:0]`≠0 or any bit above the index field is nonzero.
- FSM states: IDLE, ACCESS.
  - IDLE:
    - On `PSEL`=1 and `PENABLE`=0 (setup phase), latch `PWRITE`, `idx`, `PWDATA`, and an error flag.
    - Load wait counter `cnt`=WAIT_STATES, then go to ACCESS.
    - `PSEL`=1 with `PENABLE`=1 while in IDLE (no setup seen) is ignored.
  - ACCESS, with `PSEL`=1 and `PENABLE`=1:
    - If `cnt`≠0: decrement and stay.
    - If `cnt`=0: `PREADY`=1 this cycle; commit at the closing edge; go to IDLE.
    - The bridge's next setup, if back-to-back, arrives in the following cycle and is accepted from IDLE.
  - ACCESS with `PSEL`=0: abort. Return to IDLE with no write, no strobe, and no response.
- Error flag is set when any of these holds:
  - the address is invalid;
  - the transfer is a write to the STATUS index.
- Commit rules:
  - Write without error: `cfg_regs[idx]` ← latched data; `wr_pulse[idx]`=1 for the next cycle only.
  - Write with error: no register change, no strobe.
  - Read without error: `PRDATA` = reg[idx], or `status_in` for the STATUS index.
  - Read with error: `PRDATA`=0.
- `PREADY`, `PSLVERR` and `PRDATA` are combinational from state, `cnt`, the latched fields, and the registers. They are 0 whenever `PREADY` would be 0.
- `PWDATA`/`PADDR` changes during ACCESS are ignored; the latched values are used.

## Timing
- Reset, asynchronous and immediate:
  - state=IDLE, `cnt`=0, all config regs=0, `wr_pulse`=0.
  - `PREADY`=0, `PSLVERR`=0, `PRDATA`=0.
- Reset asserted mid-ACCESS discards the transfer; no partial write.
- Latency: setup cycle, then WAIT_STATES cycles with `PREADY`=0, then one cycle with `PREADY`=1. A transfer takes WAIT_STATES+2 cycles.
- With WAIT_STATES=0, `PREADY`=1 in the first access cycle.
- A written value is visible on `cfg_regs` one cycle after the `PREADY`=1 cycle. It is readable by the next transfer.
- STATUS is sampled combinationally during the `PREADY`=1 cycle.
- Back-to-back transfers (bridge ACCESS→SETUP) run with no idle cycle in between; the FSM passes through IDLE for exactly the setup cycle.

## Test plan
- Write, WAIT_STATES=2: write 0xDEADBEEF to 0x04.
  - `PREADY` is 0,0 then 1 in the access cycles, with `PSLVERR`=0.
  - `cfg_regs[63:32]`=0xDEADBEEF from the next cycle.
  - `wr_pulse`=0x0002 for exactly one cycle.
- Read-back and status: read 0x04, expect `PRDATA`=0xDEADBEEF with `PREADY`. Read 0x3C with `status_in`=0x0000A5A5, expect 0x0000A5A5.
- Errors:
  - Write 0x3C: `PSLVERR`=1 with `PREADY`, no strobe.
  - Read 0x40: `PSLVERR`=1, `PRDATA`=0.
  - Write 0x05: `PSLVERR`=1, regs unchanged.
- Back-to-back, WAIT_STATES=0: write 0x11 to 0x00, then immediately write 0x22 to 0x08.
  - Each transfer takes 2 cycles; both regs update.
  - `wr_pulse` shows 0x0001 then 0x0004 in successive strobe cycles.
- Abort: drop `PSEL` during the first wait cycle of a write of 0x33 to 0x0C. Reg 3 stays unchanged, `PREADY` never asserts, and the next transfer completes normally.
- Reset mid-transfer: assert `PRESETn`=0 during ACCESS of a write to 0x04.
  - Outputs go to their reset values immediately.
  - All regs are 0 after release.
  - A subsequent read of 0x04 returns 0.
